// File: rtl/mem_responder.sv
// mem_responder: single-port word memory that answers a level-held bus
// request after a fixed access latency.
//
// Ports:
//   CLK       clock, rising edge
//   nRST      asynchronous active-low reset (clears FSM and all storage)
//   dREN      read request, held until completion
//   dWEN      write request, held until completion (wins over dREN)
//   daddr     byte address; word index taken from [log2(DEPTH)+1:2]
//   dstore    write data, sampled on the completion edge
//   dwait     high while a request is outstanding, low in its completion cycle
//   dload     read data in the read completion cycle, zero otherwise
//   memstate  registered FSM state (0 idle, 1 access, 2 done)
//
// state  | meaning
// IDLE   | no access in flight; a request here starts one
// ACCESS | counting latency for the latched index/kind
// DONE   | one-cycle gap after completion; requests are ignored
module mem_responder #(
  parameter int LAT   = 2,
  parameter int DEPTH = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic [1:0]  memstate
);

  localparam int         IDX_W = $clog2(DEPTH);
  localparam logic [3:0] LAT_C = 4'(LAT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             kind_q, kind_d;
  logic [31:0]      mem_q [DEPTH];

  logic             req;
  logic [IDX_W-1:0] cur_idx;
  logic             match;
  logic             complete;
  logic             mem_we;
  logic             unused_addr_bits;

  assign req              = dREN | dWEN;
  assign cur_idx          = daddr[IDX_W+1:2];
  // Upper address bits alias; byte offset bits are don't-care.
  assign unused_addr_bits = ^{daddr[31:IDX_W+2], daddr[1:0]};

  // kind is 1 for write, so dWEN alone decides it.
  assign match    = (cur_idx == idx_q) && (dWEN == kind_q);
  assign complete = (state_q == S_ACCESS) && req && match && (cnt_q == LAT_C);
  assign mem_we   = complete && kind_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    kind_d  = kind_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_ACCESS;
          cnt_d   = 4'd1;
          idx_d   = cur_idx;
          kind_d  = dWEN;
        end
      end
      S_ACCESS: begin
        if (!req) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (!match) begin
          // Bus changed its mind mid-access: restart latency for the new target.
          cnt_d  = 4'd1;
          idx_d  = cur_idx;
          kind_d = dWEN;
        end else if (cnt_q < LAT_C) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      kind_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      kind_q  <= kind_d;
    end
  end

  // One flop row per word so every word can be cleared by the async reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        mem_q[gi] <= 32'h0;
      end else if (mem_we && (idx_q == IDX_W'(gi))) begin
        mem_q[gi] <= dstore;
      end
    end
  end

  assign dwait    = req & ~complete;
  assign dload    = (complete && !kind_q) ? mem_q[idx_q] : 32'h0;
  assign memstate = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder (LAT=2, DEPTH=64): directed scenarios with
// literal expectations, then randomized traffic checked every cycle against
// a transaction-level model (start cycle / age of the held request).
module tb_mem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 64;

  logic        CLK;
  logic        nRST;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic [1:0]  memstate;

  int n_checks = 0;
  int n_fail   = 0;

  mem_responder #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .memstate (memstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A request is "accepted" in cycle s when it is presented while not in the
  // post-completion gap; it completes in cycle s+LAT if the same target and
  // kind are held every cycle. Any change of target/kind re-accepts it.
  logic [31:0] mdl_mem [DEPTH];
  bit          mdl_busy;      // an accepted request is in flight
  bit          mdl_gap;       // this cycle follows a completion
  int          mdl_start;
  logic [5:0]  mdl_idx;
  logic        mdl_kind;
  int          mdl_cyc = 0;

  always @(negedge CLK) begin
    logic        req, kind, e_wait;
    logic [5:0]  idx;
    logic [31:0] e_load;
    logic [1:0]  e_state;
    req  = dREN | dWEN;
    kind = dWEN;
    idx  = daddr[7:2];
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'h0;
      mdl_busy = 0;
      mdl_gap  = 0;
      check("mdl_rst_state", {30'h0, memstate}, 32'd0);
      check("mdl_rst_load", dload, 32'h0);
      check("mdl_rst_wait", {31'h0, dwait}, {31'h0, req});
    end else begin
      e_state = mdl_gap ? 2'd2 : (mdl_busy ? 2'd1 : 2'd0);
      e_wait  = req;
      e_load  = 32'h0;
      if (mdl_gap) begin
        mdl_gap  = 0;
        mdl_busy = 0;
      end else if (!req) begin
        mdl_busy = 0;
      end else if (!mdl_busy || idx != mdl_idx || kind != mdl_kind) begin
        mdl_busy  = 1;
        mdl_start = mdl_cyc;
        mdl_idx   = idx;
        mdl_kind  = kind;
      end else if (mdl_cyc - mdl_start == LAT) begin
        e_wait = 1'b0;
        if (kind) mdl_mem[idx] = dstore;
        else      e_load = mdl_mem[idx];
        mdl_busy = 0;
        mdl_gap  = 1;
      end
      check("mdl_state", {30'h0, memstate}, {30'h0, e_state});
      check("mdl_wait", {31'h0, dwait}, {31'h0, e_wait});
      check("mdl_load", dload, e_load);
    end
    mdl_cyc++;
  end

  // ---------------- directed helpers ----------------
  task automatic next_cyc;
    @(posedge CLK);
    #1;
  endtask

  task automatic lit(input string name, input logic e_wait, input logic [31:0] e_load,
                     input logic [1:0] e_state);
    #3;
    check({name, "_wait"}, {31'h0, dwait}, {31'h0, e_wait});
    check({name, "_load"}, dload, e_load);
    check({name, "_state"}, {30'h0, memstate}, {30'h0, e_state});
  endtask

  // Full isolated access with LAT=2 timing, then two idle cycles.
  task automatic access(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_rd, input string name);
    dREN = ren; dWEN = wen; daddr = addr; dstore = data;
    lit({name, "_c0"}, 1'b1, 32'h0, 2'd0); next_cyc;
    lit({name, "_c1"}, 1'b1, 32'h0, 2'd1); next_cyc;
    lit({name, "_c2"}, 1'b0, wen ? 32'h0 : exp_rd, 2'd1); next_cyc;
    dREN = 0; dWEN = 0;
    lit({name, "_c3"}, 1'b0, 32'h0, 2'd2); next_cyc;
    lit({name, "_c4"}, 1'b0, 32'h0, 2'd0); next_cyc;
  endtask

  initial begin
    nRST = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
    next_cyc;
    lit("reset", 1'b0, 32'h0, 2'd0);
    dREN = 1; daddr = 32'h10;
    #1;
    check("reset_wait_follows_req", {31'h0, dwait}, 32'd1);
    dREN = 0;
    next_cyc; next_cyc;
    nRST = 1;
    next_cyc;

    access(0, 1, 32'h10, 32'hDEADBEEF, 32'h0, "wr10");
    access(1, 0, 32'h10, 32'h0, 32'hDEADBEEF, "rd10");
    access(1, 0, 32'h14, 32'h0, 32'h0, "rd14_empty");
    access(0, 1, 32'h100, 32'h12345678, 32'h0, "wr100");
    access(1, 0, 32'h000, 32'h0, 32'h12345678, "rd000_alias");
    access(0, 1, 32'h24, 32'h99, 32'h0, "wr24");
    access(1, 1, 32'h40, 32'h1, 32'h0, "both40");
    access(1, 0, 32'h40, 32'h0, 32'h1, "rd40");

    // Address change mid-access restarts latency: completion in cycle 3.
    dREN = 1; daddr = 32'h20;
    lit("chg_c0", 1'b1, 32'h0, 2'd0); next_cyc;
    daddr = 32'h24;
    lit("chg_c1", 1'b1, 32'h0, 2'd1); next_cyc;
    lit("chg_c2", 1'b1, 32'h0, 2'd1); next_cyc;
    lit("chg_c3", 1'b0, 32'h99, 2'd1); next_cyc;
    dREN = 0;
    lit("chg_c4", 1'b0, 32'h0, 2'd2); next_cyc;
    next_cyc;

    // Back-to-back held read: second completion at cycle 2*LAT+2 = 6.
    dREN = 1; daddr = 32'h10;
    lit("b2b_c0", 1'b1, 32'h0, 2'd0); next_cyc;
    lit("b2b_c1", 1'b1, 32'h0, 2'd1); next_cyc;
    lit("b2b_c2", 1'b0, 32'hDEADBEEF, 2'd1); next_cyc;
    lit("b2b_c3", 1'b1, 32'h0, 2'd2); next_cyc;
    lit("b2b_c4", 1'b1, 32'h0, 2'd0); next_cyc;
    lit("b2b_c5", 1'b1, 32'h0, 2'd1); next_cyc;
    lit("b2b_c6", 1'b0, 32'hDEADBEEF, 2'd1); next_cyc;
    dREN = 0;
    next_cyc; next_cyc;

    // Abort by dropping dWEN in cycle 1.
    dWEN = 1; daddr = 32'h30; dstore = 32'hA5A5A5A5;
    lit("abort_c0", 1'b1, 32'h0, 2'd0); next_cyc;
    dWEN = 0;
    lit("abort_c1", 1'b0, 32'h0, 2'd1); next_cyc;
    lit("abort_c2", 1'b0, 32'h0, 2'd0); next_cyc;
    access(1, 0, 32'h30, 32'h0, 32'h0, "rd30_after_abort");

    // Abort by reset pulse in cycle 1 (also clears earlier writes).
    dWEN = 1; daddr = 32'h34; dstore = 32'hA5A5A5A5;
    lit("rstab_c0", 1'b1, 32'h0, 2'd0); next_cyc;
    nRST = 0;
    lit("rstab_c1", 1'b1, 32'h0, 2'd0); next_cyc;
    nRST = 1; dWEN = 0;
    next_cyc;
    access(1, 0, 32'h34, 32'h0, 32'h0, "rd34_after_rst");
    access(1, 0, 32'h10, 32'h0, 32'h0, "rd10_after_rst");

    // Randomized traffic; the model process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      int r, mode;
      r = $urandom_range(0, 99);
      nRST = (r < 2) ? 1'b0 : 1'b1;
      if (r < 22) begin
        mode = $urandom_range(0, 9);
        dREN = (mode >= 1 && mode <= 4) || mode == 9;
        dWEN = (mode >= 5);
        daddr = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2)
              | 32'($urandom_range(0, 3));
      end else if (r < 26) begin
        daddr = {daddr[31:8], 3'b000, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      end
      dstore = $urandom;
      next_cyc;
    end
    dREN = 0; dWEN = 0; nRST = 1;
    next_cyc; next_cyc;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
